// File: rtl/alu_ctrl_unit.sv
// Registered execute stage: opcode decode, operand-B select, add/sub ALU and flags.
// Latency: 1 cycle from a sampled in_valid to out_valid with result and flags.
// Backpressure: none; accepts a new operation every cycle, idle cycles hold the result.
module alu_ctrl_unit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_reg,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             sf,
  output logic             zf,
  output logic             gf,
  output logic             reg_en,
  output logic             out_valid
);

  // opcode[0] picks SUB over ADD, opcode[1] picks the immediate as operand B
  logic             op_sub;
  logic             imm_sel;
  logic             wb_en;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   res_ext;
  logic [WIDTH-1:0] r_next;
  logic             cf_next;
  logic             sf_next;
  logic             zf_next;
  logic             gf_next;

  // Decode, operand select and the (WIDTH+1)-bit add/sub.
  // For SUB the extra top bit of the unsigned difference is exactly the borrow (a < B).
  always_comb begin
    op_sub  = opcode[0];
    imm_sel = opcode[1];
    wb_en   = (opcode != 2'b11);  // CMPI only updates flags
    b_sel   = imm_sel ? imm : b_reg;
    if (op_sub) begin
      res_ext = {1'b0, a} - {1'b0, b_sel};
    end else begin
      res_ext = {1'b0, a} + {1'b0, b_sel};
    end
    r_next  = res_ext[WIDTH-1:0];
    cf_next = res_ext[WIDTH];
    sf_next = r_next[WIDTH-1];
    zf_next = (r_next == '0);
    gf_next = ~(zf_next | sf_next);
  end

  // Result/flag register: load on a valid op, otherwise hold data and drop the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      cf        <= 1'b0;
      sf        <= 1'b0;
      zf        <= 1'b0;
      gf        <= 1'b0;
      reg_en    <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      r         <= r_next;
      cf        <= cf_next;
      sf        <= sf_next;
      zf        <= zf_next;
      gf        <= gf_next;
      reg_en    <= wb_en;
      out_valid <= 1'b1;
    end else begin
      reg_en    <= 1'b0;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with hand-computed expected outputs.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
// Expected vectors are packed as {r[4:0], cf, sf, zf, gf, reg_en, out_valid}.
module tb_alu_ctrl_unit;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [1:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] r;
  logic             cf;
  logic             sf;
  logic             zf;
  logic             gf;
  logic             reg_en;
  logic             out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ctrl_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .a         (a),
    .b_reg     (b_reg),
    .imm       (imm),
    .r         (r),
    .cf        (cf),
    .sf        (sf),
    .zf        (zf),
    .gf        (gf),
    .reg_en    (reg_en),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack expected values in the observed-vector layout.
  function automatic logic [10:0] mk(input logic [4:0] er, input logic ecf, input logic esf,
                                     input logic ezf, input logic egf, input logic een,
                                     input logic eov);
    return {er, ecf, esf, ezf, egf, een, eov};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp_v);
    logic [10:0] obs;
    obs = {r, cf, sf, zf, gf, reg_en, out_valid};
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed r/cf/sf/zf/gf/en/ov=%b required %b", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, then move to 1 unit after the capturing edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [4:0] va,
                      input logic [4:0] vb, input logic [4:0] vi);
    in_valid = v;
    opcode   = op;
    a        = va;
    b_reg    = vb;
    imm      = vi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 2'b00;
    a        = '0;
    b_reg    = '0;
    imm      = '0;

    // Reset held with random inputs: outputs stay zero
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    chk("reset_hold", mk(5'd0, 0, 0, 0, 0, 0, 0));

    // Release with in_valid low: still zero
    rst_n = 1'b1;
    step(0, 2'b00, 5'd9, 5'd9, 5'd9);
    step(0, 2'b00, 5'd9, 5'd9, 5'd9);
    chk("post_reset_idle", mk(5'd0, 0, 0, 0, 0, 0, 0));

    // ADD reg: 10 + 3 = 13
    step(1, 2'b00, 5'd10, 5'd3, 5'd0);
    chk("add_reg", mk(5'd13, 0, 0, 0, 1, 1, 1));

    // Idle: data holds, strobes drop
    step(0, 2'b01, 5'd1, 5'd1, 5'd1);
    chk("idle_hold", mk(5'd13, 0, 0, 0, 1, 0, 0));

    // SUB reg: 3 - 10 = -7 = 25, borrow
    step(1, 2'b01, 5'd3, 5'd10, 5'd0);
    chk("sub_reg_neg", mk(5'd25, 1, 1, 0, 0, 1, 1));

    // ADDI wrap: 31 + 1 = 0 carry; b_reg must be ignored
    step(1, 2'b10, 5'd31, 5'd5, 5'd1);
    chk("addi_wrap", mk(5'd0, 1, 0, 1, 0, 1, 1));

    // CMPI equal: 20 - 20 = 0, no write-back; b_reg = 7 ignored
    step(1, 2'b11, 5'd20, 5'd7, 5'd20);
    chk("cmpi_equal", mk(5'd0, 0, 0, 1, 0, 0, 1));

    // SUB reg: 0 - 1 = 31, borrow, negative
    step(1, 2'b01, 5'd0, 5'd1, 5'd0);
    chk("sub_zero_minus_one", mk(5'd31, 1, 1, 0, 0, 1, 1));

    // ADD reg: 8 + 8 = 16 is negative, no carry
    step(1, 2'b00, 5'd8, 5'd8, 5'd0);
    chk("add_sixteen_neg", mk(5'd16, 0, 1, 0, 0, 1, 1));

    // ADDI: 16 + 16 = 32 -> 0 with carry
    step(1, 2'b10, 5'd16, 5'd0, 5'd16);
    chk("addi_carry_zero", mk(5'd0, 1, 0, 1, 0, 1, 1));

    // CMPI greater: 5 - 3 = 2
    step(1, 2'b11, 5'd5, 5'd30, 5'd3);
    chk("cmpi_greater", mk(5'd2, 0, 0, 0, 1, 0, 1));

    // SUB reg with immediate bits that must be ignored: 12 - 4 = 8
    step(1, 2'b01, 5'd12, 5'd4, 5'd31);
    chk("sub_reg_pos", mk(5'd8, 0, 0, 0, 1, 1, 1));

    // Back-to-back ops, one result per cycle in order
    step(1, 2'b00, 5'd1, 5'd2, 5'd0);
    chk("b2b_add", mk(5'd3, 0, 0, 0, 1, 1, 1));
    step(1, 2'b01, 5'd7, 5'd7, 5'd0);
    chk("b2b_sub_zero", mk(5'd0, 0, 0, 1, 0, 1, 1));
    step(1, 2'b10, 5'd15, 5'd0, 5'd1);
    chk("b2b_addi_neg", mk(5'd16, 0, 1, 0, 0, 1, 1));
    step(1, 2'b11, 5'd2, 5'd0, 5'd9);
    chk("b2b_cmpi_less", mk(5'd25, 1, 1, 0, 0, 0, 1));

    // Mid-stream asynchronous reset: next op in flight, reset between edges
    in_valid = 1'b1;
    opcode   = 2'b00;
    a        = 5'd4;
    b_reg    = 5'd5;
    imm      = 5'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", mk(5'd0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("reset_held_valid_in", mk(5'd0, 0, 0, 0, 0, 0, 0));

    // Release with no valid op: out_valid stays low
    rst_n = 1'b1;
    step(0, 2'b00, 5'd4, 5'd5, 5'd0);
    chk("post_midreset_idle", mk(5'd0, 0, 0, 0, 0, 0, 0));

    // First sampled valid op after release
    step(1, 2'b00, 5'd4, 5'd5, 5'd0);
    chk("post_midreset_add", mk(5'd9, 0, 0, 0, 1, 1, 1));

    step(0, 2'b00, 5'd0, 5'd0, 5'd0);
    chk("final_idle", mk(5'd9, 0, 0, 0, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
